// File: rtl/imem_fetch_responder_pkg.sv
// rtl/imem_fetch_responder_pkg.sv - shared widths, NOP encoding and response record for the fetch responder
package imem_fetch_responder_pkg;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;

   localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [ADDR_W-1:0] addr;
      logic              err;
   } rsp_t;

   // Faulting fetches hand decode a harmless ADDI x0,x0,0 instead of memory data.
   function automatic logic [DATA_W-1:0] fetch_word(input logic err, input logic [DATA_W-1:0] word);
      return err ? NOP_INSTR : word;
   endfunction

endpackage

// File: rtl/imem_fetch_responder_rsp_fifo.sv
// rtl/imem_fetch_responder_rsp_fifo.sv - 2-entry response FIFO with flush and full/empty flags
module imem_fetch_responder_rsp_fifo
   import imem_fetch_responder_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic i_flush,
   input  logic i_push,
   input  rsp_t i_data,
   input  logic i_pop,
   output rsp_t o_data,
   output logic o_full,
   output logic o_empty
);

   rsp_t       r_slot [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_slot[0] <= '0;
         r_slot[1] <= '0;
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
      end else if (i_flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         // Push while full is legal only with a pop: it refills the slot being vacated.
         if (i_push) begin
            r_slot[r_wr_ptr] <= i_data;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (i_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_data  = r_slot[r_rd_ptr];
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);

   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(i_push && o_full && !i_pop && !i_flush));
   a_fifo_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(i_pop && o_empty));

endmodule

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - instruction fetch responder: word memory, LATENCY-deep pipe, 2-entry response FIFO
// Define IMEM_MISALIGN_CHK_EN to fault fetches whose byte address is not word aligned.
module imem_fetch_responder
   import imem_fetch_responder_pkg::*;
#(
   parameter int    DEPTH_WORDS = 1024,
   parameter int    LATENCY     = 2,
   parameter string INIT_FILE   = ""
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              flush,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_err
);

   localparam int AW    = $clog2(DEPTH_WORDS);
   localparam int CAP   = LATENCY + 2;
   localparam int CNT_W = $clog2(CAP + 1);
   localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAP);

   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
   rsp_t              r_pipe [LATENCY];
   logic [LATENCY-1:0] r_vld;
   logic [CNT_W-1:0]  r_out;
   logic              r_started;

   logic               w_acc;
   logic               w_pop;
   logic               w_err;
   logic               w_full;
   logic               w_empty;
   logic [LATENCY-1:0] w_move;
   logic [AW-1:0]      w_idx;
   rsp_t               w_new;
   rsp_t               w_head;

   initial begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] = '0;
   end

   assign w_idx = req_addr[AW+1:2];

`ifdef IMEM_MISALIGN_CHK_EN
   assign w_err = (req_addr[ADDR_W-1:AW+2] != '0) | (req_addr[1:0] != 2'b00);
`else
   logic w_unused_lsb;
   assign w_unused_lsb = ^req_addr[1:0];
   assign w_err        = (req_addr[ADDR_W-1:AW+2] != '0);
`endif

   always_comb begin
      w_new.instr = fetch_word(w_err, r_mem[w_idx]);
      w_new.addr  = req_addr;
      w_new.err   = w_err;
   end

   // Bubble-collapsing advance: a stage moves when the slot ahead is empty or moving too,
   // so a stalled FIFO never forces a pipeline result to be dropped.
   always_comb begin : p_advance
      logic v_room;
      v_room = ~w_full | w_pop;
      for (int i = LATENCY - 1; i >= 0; i--) begin
         w_move[i] = r_vld[i] & v_room;
         v_room    = ~r_vld[i] | v_room;
      end
   end

   assign req_ready = r_started & (r_out < CAP_C) & ~flush;
   assign w_acc     = req_valid & req_ready;
   assign rsp_valid = ~w_empty;
   assign w_pop     = rsp_valid & rsp_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld     <= '0;
         r_out     <= '0;
         r_started <= 1'b0;
         for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
      end else begin
         r_started <= 1'b1;
         if (flush) begin
            r_vld <= '0;
            r_out <= '0;
         end else begin
            r_out <= r_out + CNT_W'(w_acc) - CNT_W'(w_pop);
            for (int i = LATENCY - 1; i > 0; i--) begin
               if (w_move[i-1]) begin
                  r_vld[i]  <= 1'b1;
                  r_pipe[i] <= r_pipe[i-1];
               end else if (w_move[i]) begin
                  r_vld[i] <= 1'b0;
               end
            end
            if (w_acc) begin
               r_vld[0]  <= 1'b1;
               r_pipe[0] <= w_new;
            end else if (w_move[0]) begin
               r_vld[0] <= 1'b0;
            end
         end
      end
   end

   imem_fetch_responder_rsp_fifo u_rsp_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_flush (flush),
      .i_push  (w_move[LATENCY-1] & ~flush),
      .i_data  (r_pipe[LATENCY-1]),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign rsp_instr = w_head.instr;
   assign rsp_addr  = w_head.addr;
   assign rsp_err   = w_head.err;

   a_out_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(r_out == CAP_C && w_acc && !w_pop));
   a_out_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(r_out == '0 && w_pop));
   a_stage0_free: assert property (@(posedge clk) disable iff (!reset_n)
      !(w_acc && r_vld[0] && !w_move[0]));

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - scoreboard bench for imem_fetch_responder with a behavioural memory model
module tb_imem_fetch_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic        clk       = 1'b0;
   logic        reset_n   = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr  = '0;
   logic        flush     = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_addr;
   logic        rsp_err;

   int n_tests = 0;
   int n_fail  = 0;
   int n_rsp   = 0;
   int cyc     = 0;

   logic [31:0] mem_model [DEPTH];

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        err;
      int          acc;
   } exp_t;

   exp_t sb [$];
   exp_t m_e;

   logic        held       = 1'b0;
   logic        prev_flush = 1'b0;
   logic [31:0] h_instr, h_addr;
   logic        h_err;

   imem_fetch_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .flush     (flush),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_instr (rsp_instr),
      .rsp_addr  (rsp_addr),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input int c);
      exp_t e;
      logic bad;
      bad = (a >= 32'(4 * DEPTH));
`ifdef IMEM_MISALIGN_CHK_EN
      if ((a % 4) != 0) bad = 1'b1;
`endif
      e.addr  = a;
      e.err   = bad;
      e.acc   = c;
      e.instr = 32'h0000_0013;
      if (!bad) e.instr = mem_model[int'(a / 4)];
      return e;
   endfunction

   // Monitor: checks on every handshake, then records what the DUT will accept at the coming edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         sb.delete();
         held       = 1'b0;
         prev_flush = 1'b0;
      end else begin
         if (held && !prev_flush) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_instr", rsp_instr, h_instr);
            check("hold_addr",  rsp_addr,  h_addr);
            check("hold_err",   rsp_err,   h_err);
         end
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rsp_unexpected: got addr 0x%08h with no request outstanding", rsp_addr);
            end else begin
               m_e = sb.pop_front();
               check("rsp_addr",  rsp_addr,  m_e.addr);
               check("rsp_instr", rsp_instr, m_e.instr);
               check("rsp_err",   rsp_err,   m_e.err);
               n_tests++;
               if (cyc - m_e.acc < LAT + 1) begin
                  n_fail++;
                  $display("FAIL rsp_latency: got %0d cycles need at least %0d", cyc - m_e.acc, LAT + 1);
               end
            end
         end
         held    = rsp_valid && !rsp_ready;
         h_instr = rsp_instr;
         h_addr  = rsp_addr;
         h_err   = rsp_err;
         prev_flush = flush;
         if (flush) sb.delete();
         else if (req_valid && req_ready) sb.push_back(model(req_addr, cyc));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, output int stalls);
      stalls    = 0;
      req_valid = 1'b1;
      req_addr  = a;
      @(negedge clk);
      while (!req_ready && stalls < 100) begin
         stalls++;
         @(negedge clk);
      end
      if (!req_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL issue_timeout: got no req_ready for addr 0x%08h within 100 cycles", a);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200; k++) begin
         if (sb.size() == 0 && !rsp_valid) break;
         tick();
      end
      check("drain_empty", sb.size(), 0);
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(9, 0);
      if (r < 6) return 32'($urandom_range(DEPTH - 1, 0) * 4);
      if (r < 8) return 32'($urandom_range(4 * DEPTH - 1, 0));
      return 32'h0000_1000 + ($urandom & 32'h7FFF_FFF0);
   endfunction

   initial begin
      int s;
      int acc;
      int stalls;
      int base;
      logic ok;

      #1;
      for (int i = 0; i < DEPTH; i++) begin
         mem_model[i]  = $urandom;
         dut.r_mem[i]  = mem_model[i];
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_instr", rsp_instr, 0);
      check("rst_rsp_addr",  rsp_addr,  0);
      check("rst_rsp_err",   rsp_err,   0);
      reset_n = 1'b1;
      @(negedge clk);
      check("rel_ready_before_edge", req_ready, 0);
      @(negedge clk);
      check("rel_ready_after_edge", req_ready, 1);
      tick();

      // Back-to-back streaming with a willing consumer.
      rsp_ready = 1'b1;
      stalls    = 0;
      base      = n_rsp;
      for (int i = 0; i < 16; i++) begin
         issue(32'(i * 4), s);
         stalls += s;
      end
      check("stream_stalls", stalls, 0);
      drain();
      check("stream_count", n_rsp - base, 16);

      // Consumer stalls: only CAP requests may be taken.
      rsp_ready = 1'b0;
      acc       = 0;
      req_valid = 1'b1;
      req_addr  = 32'($urandom_range(DEPTH - 1, 0) * 4);
      repeat (10) begin
         @(negedge clk);
         ok = req_ready;
         if (ok) acc++;
         tick();
         if (ok) req_addr = 32'($urandom_range(DEPTH - 1, 0) * 4);
      end
      req_valid = 1'b0;
      check("bp_accepts", acc, LAT + 2);
      check("bp_ready_low", req_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      base      = n_rsp;
      rsp_ready = 1'b1;
      drain();
      check("bp_count", n_rsp - base, LAT + 2);

      // Flush with three in flight, then a clean fetch of word 64.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) issue(32'($urandom_range(DEPTH - 1, 0) * 4), s);
      flush     = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0000_0200;
      @(negedge clk);
      check("flush_req_ready", req_ready, 0);
      tick();
      flush     = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      check("flush_rsp_valid", rsp_valid, 0);
      tick();
      rsp_ready = 1'b1;
      base      = n_rsp;
      issue(32'h0000_0100, s);
      drain();
      check("flush_count", n_rsp - base, 1);

      // Range and alignment boundaries.
      base = n_rsp;
      issue(32'h0000_1000, s);
      issue(32'h0000_0006, s);
      issue(32'h0000_0FFC, s);
      issue(32'hFFFF_FFFC, s);
      drain();
      check("edge_count", n_rsp - base, 4);

      // Random traffic with random backpressure and occasional flushes.
      for (int k = 0; k < 500; k++) begin
         rsp_ready = ($urandom_range(9, 0) < 7);
         flush     = ($urandom_range(39, 0) == 0);
         req_valid = ($urandom_range(9, 0) < 7);
         req_addr  = rand_addr();
         tick();
      end
      flush     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      drain();

      // Reset with requests outstanding.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) issue(32'($urandom_range(DEPTH - 1, 0) * 4), s);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_req_ready", req_ready, 0);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_rsp_instr", rsp_instr, 0);
      check("mid_rst_rsp_addr",  rsp_addr,  0);
      check("mid_rst_rsp_err",   rsp_err,   0);
      @(posedge clk);
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      check("mid_rel_ready_before_edge", req_ready, 0);
      @(negedge clk);
      check("mid_rel_ready_after_edge", req_ready, 1);
      rsp_ready = 1'b1;
      base      = n_rsp;
      repeat (10) tick();
      check("post_reset_no_rsp", n_rsp - base, 0);
      issue(32'h0000_0004, s);
      drain();
      check("post_reset_count", n_rsp - base, 1);

      check("final_sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
